sram_port_sequencer: RTL
========================

// Module: sram_port_sequencer
// PURPOSE
//  Upstream stage of sram_2port_bank. Accepts register-file read/write requests and drives the bank.
//  Each request maps to one Bennett frame; the sequencer times Addr_A/Addr_B, write data, ReadEn
//  and WriteEn against the frame. It captures outA/outB and returns them as a one-cycle response.
//  Runs on the same clk as bennett_clock; frames are delimited by frame_start (bennett instFlag).
// PARAMETERS
//  DATA_W     16  data width (bank word)
//  ADDR_W     5   address width per port
//  FRAME_LEN  20  clk cycles per Bennett frame (legal range 12..255)
//  ADDR_CYC   2   frame cycle in which Addr_A/Addr_B are updated
//  DATA_CYC   4   frame cycle in which wdata is updated
//  RD_ON/RD_OFF  6/8  ReadEn high for fcnt in [RD_ON,RD_OFF)
//  WR_ON/WR_OFF  8/9  WriteEn high for fcnt in [WR_ON,WR_OFF)
//  CAP_CYC    10  frame cycle in which outA/outB are sampled
//  Required ordering: ADDR_CYC<DATA_CYC<=RD_ON<RD_OFF<=WR_ON<WR_OFF<=CAP_CYC<FRAME_LEN-1.
// PORTS
//  clk          in   1       system clock (same clock as bennett_clock)
//  reset        in   1       asynchronous, active-low reset
//  frame_start  in   1       one-cycle pulse marking frame cycle 0
//  req_valid    in   1       request offered
//  req_ready    out  1       request slot free
//  req_rd       in   1       read op: return words at req_addr_a and req_addr_b
//  req_wr       in   1       write op: write req_wdata to req_addr_a
//  req_addr_a   in   ADDR_W  port A address (read and write)
//  req_addr_b   in   ADDR_W  port B address (read only)
//  req_wdata    in   DATA_W  write data
//  Addr_A       out  ADDR_W  to bank Addr_A
//  Addr_B       out  ADDR_W  to bank Addr_B
//  ReadEn       out  1       to bank ReadEn
//  WriteEn      out  1       to bank WriteEn
//  wdata        out  DATA_W  to bank `in`
//  outA/outB    in   DATA_W  from bank read ports
//  rsp_valid    out  1       one-cycle pulse: rsp_a/rsp_b valid
//  rsp_a/rsp_b  out  DATA_W  captured outA/outB
//  busy         out  1       op active in current frame
//  sync_err     out  1       one-cycle pulse: frame_start arrived before frame end
// BEHAVIOUR
//  Reset (reset=0, async):
//   - All outputs 0 except req_ready=1.
//   - fcnt=0; pending and active slots are emptied.
//  Request intake:
//   - One-deep pending slot; req_ready = ~pending_full.
//   - A request is accepted on the clk edge where req_valid&req_ready.
//   - A request with req_rd=req_wr=0 is accepted and discarded.
//  Frame counter:
//   - The edge that samples frame_start=1 sets fcnt=0; otherwise fcnt increments each clk.
//   - fcnt saturates at FRAME_LEN-1.
//  Issue:
//   - On the frame_start edge, the pending request (if any) moves to active and busy=1.
//   - req_ready rises in the same cycle.
//   - A request accepted on that same edge stays pending for the next frame.
//   - No pending request means the frame is idle: bank outputs hold their values, enables stay 0.
//  Active FSM (IDLE->ACTIVE->IDLE):
//   - Addr_A/Addr_B load from the op when fcnt==ADDR_CYC.
//   - wdata loads when fcnt==DATA_CYC (write ops only).
//   - ReadEn follows its window if rd; WriteEn follows its window if wr.
//   - All are registered from next-fcnt compares, so they change on the edge entering the stated cycle.
//   - When fcnt==CAP_CYC and rd: rsp_a<=outA, rsp_b<=outB, rsp_valid=1 for exactly one cycle.
//   - rsp_a/rsp_b hold until the next capture.
//   - busy clears at CAP_CYC+1. No response backpressure.
//  Combined rd&wr: the read window precedes the write window, so rsp_a returns the OLD word at addr_a.
//   - The new value is visible from the next frame.
//  Early frame_start while ACTIVE with fcnt<CAP_CYC:
//   - sync_err pulses; the active op is aborted (enables 0 next edge, no rsp_valid).
//   - The pending op (if any) starts in the new frame.
//  frame_start at fcnt>=CAP_CYC is normal; no error.
//  Reset mid-frame: the op is dropped with no response. Enables go 0 immediately (async).
// TESTING
//  1. Reset release, idle frames -> req_ready=1; ReadEn=WriteEn=0; Addr_A=Addr_B=0; no rsp_valid.
//  2. Write addr_a=1, wdata=16'hAAAA, then read a=1 b=0 next frame
//     -> write frame: WriteEn high in cycle 8 only. Read frame: rsp_valid at cycle 11, rsp_a=16'hAAAA.
//  3. Combined rd&wr to addr 3, old=16'h1234, new=16'h5678 -> rsp_a=16'h1234.
//     Read of addr 3 in the next frame -> 16'h5678.
//  4. Two back-to-back requests mid-frame -> first accepted and req_ready=0; second held.
//     Both are issued on consecutive frame_starts in order.
//  5. frame_start at fcnt=7 during a read -> sync_err=1 for one cycle; ReadEn drops; no rsp_valid.
//     The pending op runs in the new frame.
//  6. reset=0 at fcnt=8 during a write -> WriteEn=0 immediately.
//     After release: req_ready=1 and the word is not written (a read returns its prior value).

Source files
------------

// File: rtl/sram_port_sequencer_if.sv
// Request, bank and response signals of the SRAM port sequencer.
// The sequencer takes the slave view; the requester/bank environment takes the master view.
interface sram_port_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic              frame_start;
    logic              req_valid;
    logic              req_ready;
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr_a;
    logic [ADDR_W-1:0] req_addr_b;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] Addr_A;
    logic [ADDR_W-1:0] Addr_B;
    logic              ReadEn;
    logic              WriteEn;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] outA;
    logic [DATA_W-1:0] outB;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_a;
    logic [DATA_W-1:0] rsp_b;
    logic              busy;
    logic              sync_err;

    modport slave (
        input  frame_start, req_valid, req_rd, req_wr, req_addr_a, req_addr_b, req_wdata,
        input  outA, outB,
        output req_ready, Addr_A, Addr_B, ReadEn, WriteEn, wdata,
        output rsp_valid, rsp_a, rsp_b, busy, sync_err
    );

    modport master (
        output frame_start, req_valid, req_rd, req_wr, req_addr_a, req_addr_b, req_wdata,
        output outA, outB,
        input  req_ready, Addr_A, Addr_B, ReadEn, WriteEn, wdata,
        input  rsp_valid, rsp_a, rsp_b, busy, sync_err
    );
endinterface

// File: rtl/sram_port_sequencer.sv
// Maps one register-file request per Bennett frame onto the 2-port SRAM bank, timing the
// address, data and enables against the frame counter and returning captured read data.
module sram_port_sequencer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned FRAME_LEN = 20,
    parameter int unsigned ADDR_CYC  = 2,
    parameter int unsigned DATA_CYC  = 4,
    parameter int unsigned RD_ON     = 6,
    parameter int unsigned RD_OFF    = 8,
    parameter int unsigned WR_ON     = 8,
    parameter int unsigned WR_OFF    = 9,
    parameter int unsigned CAP_CYC   = 10
) (
    input logic                 clk,
    input logic                 reset,
    sram_port_sequencer_if.slave bus
);
    localparam logic [7:0] FcntMax = 8'(FRAME_LEN - 1);
    localparam logic [7:0] AddrCyc = 8'(ADDR_CYC);
    localparam logic [7:0] DataCyc = 8'(DATA_CYC);
    localparam logic [7:0] RdOn    = 8'(RD_ON);
    localparam logic [7:0] RdOff   = 8'(RD_OFF);
    localparam logic [7:0] WrOn    = 8'(WR_ON);
    localparam logic [7:0] WrOff   = 8'(WR_OFF);
    localparam logic [7:0] CapCyc  = 8'(CAP_CYC);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
        logic [DATA_W-1:0] wdata;
    } op_t;

    state_e            state_q, state_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              pend_full_q, pend_full_d;
    op_t               pend_q, pend_d;
    op_t               act_q, act_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              read_en_q, read_en_d;
    logic              write_en_q, write_en_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0] rsp_b_q, rsp_b_d;
    logic              sync_err_q, sync_err_d;
    logic              active_d;

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pend_full_d = pend_full_q;
        pend_d      = pend_q;
        act_d       = act_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        wdata_d     = wdata_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        rsp_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        if (bus.frame_start) begin
            fcnt_d = '0;
        end else if (fcnt_q != FcntMax) begin
            fcnt_d = fcnt_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.frame_start && pend_full_q) state_d = StActive;
            end
            StActive: begin
                // A new frame before capture abandons the running op.
                if (bus.frame_start) begin
                    sync_err_d = (fcnt_q < CapCyc);
                    state_d    = pend_full_q ? StActive : StIdle;
                end else if (fcnt_q == CapCyc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Issue needs a full slot, intake an empty one, so they never coincide.
        if (bus.frame_start && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end else if (bus.req_valid && !pend_full_q && (bus.req_rd || bus.req_wr)) begin
            pend_d      = '{rd: bus.req_rd, wr: bus.req_wr, addr_a: bus.req_addr_a,
                            addr_b: bus.req_addr_b, wdata: bus.req_wdata};
            pend_full_d = 1'b1;
        end

        if (state_q == StActive && act_q.rd && fcnt_q == CapCyc) begin
            rsp_valid_d = 1'b1;
            rsp_a_d     = bus.outA;
            rsp_b_d     = bus.outB;
        end

        // Bank-facing outputs are decoded from the next frame cycle so they are registered.
        active_d = (state_d == StActive);
        if (active_d && fcnt_d == AddrCyc) begin
            addr_a_d = act_d.addr_a;
            addr_b_d = act_d.addr_b;
        end
        if (active_d && act_d.wr && fcnt_d == DataCyc) wdata_d = act_d.wdata;
        read_en_d  = active_d && act_d.rd && (fcnt_d >= RdOn) && (fcnt_d < RdOff);
        write_en_d = active_d && act_d.wr && (fcnt_d >= WrOn) && (fcnt_d < WrOff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            fcnt_q      <= '0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            act_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            wdata_q     <= '0;
            read_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            wdata_q     <= wdata_d;
            read_en_q   <= read_en_d;
            write_en_q  <= write_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.req_ready = ~pend_full_q;
    assign bus.Addr_A    = addr_a_q;
    assign bus.Addr_B    = addr_b_q;
    assign bus.wdata     = wdata_q;
    assign bus.ReadEn    = read_en_q;
    assign bus.WriteEn   = write_en_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_a     = rsp_a_q;
    assign bus.rsp_b     = rsp_b_q;
    assign bus.busy      = (state_q == StActive);
    assign bus.sync_err  = sync_err_q;
endmodule
